sseg_scan_display: RTL and testbench

//  Consumer side of the ALU result path.
//  - Latches a signed-magnitude result (value + sign) on a load strobe.
//  - Converts value to BCD with a serial double-dabble FSM.
//  - Time-multiplexes 4 common-anode 7-segment digits:

---
 rtl/sseg_scan_display.sv | 165 ++++++++++++++++
 tb/tb_sseg_scan_display.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_display.sv
// Latches a signed-magnitude result, converts it to BCD with a serial double-dabble
// FSM and scans it onto four common-anode 7-segment digits (units, tens, hundreds, sign).
module sseg_scan_display #(
  parameter int unsigned DATA_W      = 6,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              signo,
  input  logic              load,
  output logic              busy,
  output logic [0:6]        sseg,
  output logic [3:0]        an
);

  localparam int unsigned BCD_W  = 12;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  shadow;
  logic               shadow_sign;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   disp_bcd;
  logic               disp_sign;

  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_tc;
  logic [1:0]         digit_idx;
  logic [1:0]         digit_nxt;
  logic [3:0]         an_nxt;
  logic [0:6]         seg_nxt;
  logic [3:0]         units;
  logic [3:0]         tens;
  logic [3:0]         hundreds;
  logic               hund_blank;
  logic               tens_blank;
  logic               sign_on;

  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM; display regs only change in DONE so partial results never show.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      shadow      <= '0;
      shadow_sign <= 1'b0;
      bcd         <= '0;
      bit_cnt     <= '0;
      disp_bcd    <= '0;
      disp_sign   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            shadow      <= value;
            shadow_sign <= signo;
            bcd         <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            state       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd     <= (bcd_adj << 1) | BCD_W'(shadow[DATA_W-1]);
          shadow  <= shadow << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          disp_bcd  <= bcd;
          disp_sign <= shadow_sign;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign units      = disp_bcd[3:0];
  assign tens       = disp_bcd[7:4];
  assign hundreds   = disp_bcd[11:8];
  assign hund_blank = (hundreds == 4'd0);
  assign tens_blank = hund_blank && (tens == 4'd0);
  assign sign_on    = disp_sign && (disp_bcd != '0);

  assign scan_tc   = (scan_cnt == SCAN_W'(REFRESH_DIV - 1));
  assign digit_nxt = scan_tc ? digit_idx + 2'd1 : digit_idx;

  // an and sseg are derived from the same next digit index so they switch together.
  always_comb begin
    an_nxt            = 4'b1111;
    an_nxt[digit_nxt] = 1'b0;
  end

  always_comb begin
    seg_nxt = SEG_BLANK;
    case (digit_nxt)
      2'd0:    seg_nxt = seg7(units);
      2'd1:    if (!tens_blank) seg_nxt = seg7(tens);
      2'd2:    if (!hund_blank) seg_nxt = seg7(hundreds);
      default: if (sign_on) seg_nxt = SEG_MINUS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
      an        <= 4'b1110;
      sseg      <= 7'b0000001;
    end else begin
      scan_cnt  <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
      digit_idx <= digit_nxt;
      an        <= an_nxt;
      sseg      <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_scan_display.sv
// Directed bench for sseg_scan_display with a short refresh period.
module tb_sseg_scan_display;

  localparam int unsigned DW = 6;
  localparam int unsigned RD = 4;

  localparam logic [0:6] BLANK = 7'b1111111;
  localparam logic [0:6] MINUS = 7'b1111110;
  localparam logic [0:6] D0 = 7'b0000001;
  localparam logic [0:6] D2 = 7'b0010010;
  localparam logic [0:6] D3 = 7'b0000110;
  localparam logic [0:6] D4 = 7'b1001100;
  localparam logic [0:6] D6 = 7'b0100000;
  localparam logic [0:6] D7 = 7'b0001111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] value = '0;
  logic          signo = 1'b0;
  logic          load = 1'b0;
  logic          busy;
  logic [0:6]    sseg;
  logic [3:0]    an;

  int tests = 0;
  int fails = 0;

  sseg_scan_display #(.DATA_W(DW), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value(value), .signo(signo), .load(load),
    .busy(busy), .sseg(sseg), .an(an)
  );

  always #5 clk = ~clk;

  // Waits until digit d is enabled and returns its segments; ok=0 on timeout.
  task automatic sample_digit(input int d, output logic [0:6] seg, output bit ok);
    logic [3:0] want;
    want = 4'b1111 ^ (4'b0001 << d);
    ok   = 1'b0;
    seg  = 'x;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (an === want) begin
        ok  = 1'b1;
        seg = sseg;
      end
    end
  endtask

  task automatic do_load(input logic [DW-1:0] v, input logic s);
    @(negedge clk);
    value = v;
    signo = s;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  // Bounded wait for busy to drop, plus settle cycles for the registered outputs.
  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    rst  = 1'b1;
    load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests++;
    if (an !== 4'b1110) begin fails++; $display("FAIL reset_an: got %b required 1110", an); end
    tests++;
    if (sseg !== D0) begin fails++; $display("FAIL reset_sseg: got %b required %b", sseg, D0); end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      exp_an = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
      tests++;
      if (an !== exp_an) begin
        fails++;
        $display("FAIL reset_scan_an k=%0d: got %b required %b", k, an, exp_an);
      end
      tests++;
      if (sseg !== ((exp_an == 4'b1110) ? D0 : BLANK)) begin
        fails++;
        $display("FAIL reset_scan_sseg k=%0d: got %b required %b", k, sseg,
                 (exp_an == 4'b1110) ? D0 : BLANK);
      end
    end
  endtask

  task automatic test_load_42();
    logic [0:6] exp [4];
    logic [0:6] seg;
    bit ok;
    int n = 0;
    exp[0] = D2; exp[1] = D4; exp[2] = BLANK; exp[3] = BLANK;
    do_load(6'd42, 1'b0);
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    tests++;
    if (n != DW + 1) begin fails++; $display("FAIL load42_busy_cycles: got %0d required %0d", n, DW + 1); end
    wait_idle("load42");
    for (int d = 0; d < 4; d++) begin
      sample_digit(d, seg, ok);
      tests++;
      if (!ok || seg !== exp[d]) begin
        fails++;
        $display("FAIL load42_digit%0d: got %b (found=%0d) required %b", d, seg, ok, exp[d]);
      end
    end
  endtask

  task automatic test_negative_63();
    logic [0:6] exp [4];
    logic [0:6] seg;
    bit ok;
    exp[0] = D3; exp[1] = D6; exp[2] = BLANK; exp[3] = MINUS;
    do_load(6'd63, 1'b1);
    wait_idle("neg63");
    for (int d = 0; d < 4; d++) begin
      sample_digit(d, seg, ok);
      tests++;
      if (!ok || seg !== exp[d]) begin
        fails++;
        $display("FAIL neg63_digit%0d: got %b (found=%0d) required %b", d, seg, ok, exp[d]);
      end
    end
  endtask

  task automatic test_load_while_busy();
    logic [0:6] exp [4];
    logic [0:6] seg;
    bit ok;
    exp[0] = D7; exp[1] = BLANK; exp[2] = BLANK; exp[3] = BLANK;
    do_load(6'd7, 1'b0);
    @(posedge clk);
    do_load(6'd55, 1'b1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_drop_busy: got %b required 1", busy); end
    wait_idle("busy_drop");
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_drop_queued: busy=%b required 0", busy); end
    for (int d = 0; d < 4; d++) begin
      sample_digit(d, seg, ok);
      tests++;
      if (!ok || seg !== exp[d]) begin
        fails++;
        $display("FAIL busy_drop_digit%0d: got %b (found=%0d) required %b", d, seg, ok, exp[d]);
      end
    end
  endtask

  task automatic test_negative_zero();
    logic [0:6] exp [4];
    logic [0:6] seg;
    bit ok;
    exp[0] = D0; exp[1] = BLANK; exp[2] = BLANK; exp[3] = BLANK;
    do_load(6'd0, 1'b1);
    wait_idle("negzero");
    for (int d = 0; d < 4; d++) begin
      sample_digit(d, seg, ok);
      tests++;
      if (!ok || seg !== exp[d]) begin
        fails++;
        $display("FAIL negzero_digit%0d: got %b (found=%0d) required %b", d, seg, ok, exp[d]);
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    logic [0:6] exp [4];
    logic [0:6] seg;
    bit ok;
    exp[0] = D0; exp[1] = BLANK; exp[2] = BLANK; exp[3] = BLANK;
    do_load(6'd42, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy3: got %b required 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b required 0", busy); end
    tests++;
    if (an !== 4'b1110) begin fails++; $display("FAIL midrst_an: got %b required 1110", an); end
    tests++;
    if (sseg !== D0) begin fails++; $display("FAIL midrst_sseg: got %b required %b", sseg, D0); end
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_resume: busy=%b required 0", busy); end
    for (int d = 0; d < 4; d++) begin
      sample_digit(d, seg, ok);
      tests++;
      if (!ok || seg !== exp[d]) begin
        fails++;
        $display("FAIL midrst_digit%0d: got %b (found=%0d) required %b", d, seg, ok, exp[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_42();
    test_negative_63();
    test_load_while_busy();
    test_negative_zero();
    test_reset_mid_conversion();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
